// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 controller.
// Contents: block width, FSM state type, the round-constant table, the S-box
// lookup function and the word-level helpers used in round-key expansion.
package aes_pkg;

    localparam int unsigned AES_BLK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } aes_fsm_e;

    // Round constants for rounds 1..10, stored at index round-1.
    localparam logic [0:9][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [0:255][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX_TBL[a];
    endfunction

    // Round constant for round rc; zero outside 1..10.
    function automatic logic [7:0] rcon_of(input logic [3:0] rc);
        if (rc == 4'd0 || rc > 4'd10) begin
            return '0;
        end
        return RCON[rc - 4'd1];
    endfunction

    function automatic logic [31:0] rotword(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // One key-expansion step; subw is SubWord(RotWord(last word of rk)).
    function automatic logic [127:0] key_step(input logic [127:0] rk,
                                              input logic [31:0]  subw,
                                              input logic [7:0]   rcon);
        logic [31:0] w0, w1, w2, w3;
        w0 = rk[127:96] ^ subw ^ {rcon, 24'h000000};
        w1 = rk[95:64]  ^ w0;
        w2 = rk[63:32]  ^ w1;
        w3 = rk[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// Combinational next-round-key generator for AES-128.
// Ports: rk_i - current round key; rcon_i - round constant for the step;
//        key_o - next round key.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk_i,
    input  logic [7:0]   rcon_i,
    output logic [127:0] key_o
);

    logic [31:0] rot;
    logic [31:0] sub;

    assign rot = rotword(rk_i[31:0]);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .a_i (rot[8*g +: 8]),
            .s_o (sub[8*g +: 8])
        );
    end

    assign key_o = key_step(rk_i, sub, rcon_i);

endmodule

// File: rtl/aes_sbox.sv
// Single-byte AES S-box lookup.
// Ports: a_i - input byte; s_o - substituted byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);

    assign s_o = sbox(a_i);

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption controller. Drives an external one-round
// datapath through NR rounds, expanding round keys on the fly.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   in_valid/in_ready/in_plain/in_key - request handshake and block + key
//   out_valid/out_ready/out_cipher    - result handshake and ciphertext
//   rnd_state_o/rnd_key_o/rnd_last_o  - operands presented to the datapath
//   rnd_state_i                       - datapath result
//   busy                              - controller not idle
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR     = 10,
    parameter int unsigned DP_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_plain,
    input  logic [AES_BLK_W-1:0] in_key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_cipher,
    output logic [AES_BLK_W-1:0] rnd_state_o,
    output logic [AES_BLK_W-1:0] rnd_key_o,
    output logic                 rnd_last_o,
    input  logic [AES_BLK_W-1:0] rnd_state_i,
    output logic                 busy
);

    if (NR != 10) begin : g_nr_check
        $error("aes_round_ctrl: only NR=10 is supported");
    end
    if (DP_LAT > 1) begin : g_lat_check
        $error("aes_round_ctrl: DP_LAT must be 0 or 1");
    end

    localparam logic [3:0] RC_LAST   = 4'(NR);
    localparam logic       WAIT_LAST = 1'(DP_LAT);

    aes_fsm_e             fsm_q;
    logic [AES_BLK_W-1:0] state_q;
    logic [AES_BLK_W-1:0] rk_q;
    logic [AES_BLK_W-1:0] key_d;
    logic [3:0]           rc_q;
    logic                 wait_q;

    logic in_round;
    logic accept;
    logic hold_last;
    logic round_bad;

    aes_key_step u_key_step (
        .rk_i   (rk_q),
        .rcon_i (rcon_of(rc_q)),
        .key_o  (key_d)
    );

    assign in_round  = (fsm_q == ST_ROUND);
    assign out_valid = (fsm_q == ST_DONE);
    assign busy      = (fsm_q != ST_IDLE);

    // Ready also reflects out_ready while DONE so a new block can be taken in
    // the same cycle as the result handshake; held low during reset.
    assign in_ready = ~rst & ((fsm_q == ST_IDLE) | ((fsm_q == ST_DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    assign hold_last = (wait_q == WAIT_LAST);
    // Counters outside their legal range end the block instead of running on.
    assign round_bad = (rc_q == 4'd0) || (rc_q > RC_LAST) || (wait_q > WAIT_LAST);

    // Datapath operands are zeroed outside ROUND so nothing leaks when idle.
    assign rnd_state_o = in_round ? state_q : '0;
    assign rnd_key_o   = in_round ? key_d : '0;
    assign rnd_last_o  = in_round & (rc_q == RC_LAST);
    assign out_cipher  = out_valid ? state_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            rk_q    <= '0;
            rc_q    <= '0;
            wait_q  <= '0;
        end else if (accept) begin
            state_q <= in_plain ^ in_key;
            rk_q    <= in_key;
            rc_q    <= 4'd1;
            wait_q  <= '0;
            fsm_q   <= ST_ROUND;
        end else begin
            case (fsm_q)
                ST_ROUND: begin
                    if (round_bad) begin
                        wait_q <= '0;
                        fsm_q  <= ST_DONE;
                    end else if (hold_last) begin
                        state_q <= rnd_state_i;
                        rk_q    <= key_d;
                        wait_q  <= '0;
                        if (rc_q == RC_LAST) begin
                            fsm_q <= ST_DONE;
                        end else begin
                            rc_q <= rc_q + 4'd1;
                        end
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        fsm_q <= ST_IDLE;
                    end
                end
                ST_IDLE: ;
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: instance a uses a combinational
// round datapath (DP_LAT=0), instance b a registered one (DP_LAT=1). The
// datapath model computes the S-box arithmetically in GF(2^8).
module tb_aes_round_ctrl;

    localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] S0B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] RK1B = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KC   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] RK1C = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

    logic clk;
    logic rst;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_rnd_last_o, a_busy;
    logic [127:0] a_in_plain, a_in_key, a_out_cipher, a_rnd_state_o, a_rnd_key_o, a_rnd_state_i;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_rnd_last_o, b_busy;
    logic [127:0] b_in_plain, b_in_key, b_out_cipher, b_rnd_state_o, b_rnd_key_o, b_rnd_state_i;

    int n_tests;
    int n_fail;

    aes_round_ctrl #(.NR(10), .DP_LAT(0)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_plain(a_in_plain), .in_key(a_in_key),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_cipher(a_out_cipher),
        .rnd_state_o(a_rnd_state_o), .rnd_key_o(a_rnd_key_o), .rnd_last_o(a_rnd_last_o),
        .rnd_state_i(a_rnd_state_i), .busy(a_busy)
    );

    aes_round_ctrl #(.NR(10), .DP_LAT(1)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_plain(b_in_plain), .in_key(b_in_key),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_cipher(b_out_cipher),
        .rnd_state_o(b_rnd_state_o), .rnd_key_o(b_rnd_key_o), .rnd_last_o(b_rnd_last_o),
        .rnd_state_i(b_rnd_state_i), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural round model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] msbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] r;
        logic [7:0] s;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        s = inv;
        r = inv;
        for (int i = 0; i < 4; i++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] model_round(input logic [127:0] st, input logic [127:0] key,
                                                 input logic last);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = msbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r+4*c] = s[r + 4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ key;
    endfunction

    always_comb a_rnd_state_i = model_round(a_rnd_state_o, a_rnd_key_o, a_rnd_last_o);

    always @(posedge clk) b_rnd_state_i <= model_round(b_rnd_state_o, b_rnd_key_o, b_rnd_last_o);

    // ---------------- stimulus helper ----------------
    // Enter and leave at #1 after a rising edge; returns in cycle T+1.
    task automatic send(input bit to_b, input logic [127:0] p, input logic [127:0] k);
        int n;
        n = 0;
        if (to_b) begin b_in_plain = p; b_in_key = k; b_in_valid = 1'b1; end
        else begin a_in_plain = p; a_in_key = k; a_in_valid = 1'b1; end
        while (((to_b ? b_in_ready : a_in_ready) !== 1'b1) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        n_tests++;
        if (n >= 50) begin
            n_fail++;
            $display("FAIL send_ready: waited %0d cycles, required < 50", n);
        end
        @(posedge clk); #1;
        if (to_b) b_in_valid = 1'b0; else a_in_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_in_ready: got %b expected 0", a_in_ready); end
        n_tests++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_in_ready: got %b expected 0", b_in_ready); end
        n_tests++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_a_flags: got valid=%b busy=%b expected 0 0", a_out_valid, a_busy); end
        n_tests++; if (b_out_valid !== 1'b0 || b_busy !== 1'b0) begin n_fail++; $display("FAIL reset_b_flags: got valid=%b busy=%b expected 0 0", b_out_valid, b_busy); end
        n_tests++; if ({a_rnd_state_o, a_rnd_key_o, a_out_cipher} !== '0 || a_rnd_last_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_a_data: got st=%h key=%h ct=%h last=%b expected all 0", a_rnd_state_o, a_rnd_key_o, a_out_cipher, a_rnd_last_o); end
        rst = 1'b0;
        a_out_ready = 1'b0; b_out_ready = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got a=%b b=%b expected 1 1", a_in_ready, b_in_ready); end
    endtask

    task automatic test_fips_b();
        int cyc, last_n, last_at;
        a_out_ready = 1'b0;
        send(1'b0, PB, KB);
        n_tests++; if (a_rnd_key_o !== RK1B) begin n_fail++; $display("FAIL fips_b_rk1: got %h expected %h", a_rnd_key_o, RK1B); end
        n_tests++; if (a_rnd_state_o !== S0B) begin n_fail++; $display("FAIL fips_b_state0: got %h expected %h", a_rnd_state_o, S0B); end
        cyc = 1; last_n = 0; last_at = 0;
        while (a_out_valid !== 1'b1 && cyc < 40) begin
            if (a_rnd_last_o === 1'b1) begin last_n++; last_at = cyc; end
            @(posedge clk); #1; cyc++;
        end
        n_tests++; if (cyc != 11) begin n_fail++; $display("FAIL fips_b_latency: got T+%0d expected T+11", cyc); end
        n_tests++; if (last_n != 1 || last_at != 10) begin n_fail++; $display("FAIL fips_b_last: got %0d cycles ending T+%0d expected 1 at T+10", last_n, last_at); end
        n_tests++; if (a_out_cipher !== CB) begin n_fail++; $display("FAIL fips_b_cipher: got %h expected %h", a_out_cipher, CB); end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        n_tests++; if (a_busy !== 1'b0 || a_out_valid !== 1'b0) begin n_fail++; $display("FAIL fips_b_release: got busy=%b valid=%b expected 0 0", a_busy, a_out_valid); end
    endtask

    task automatic test_fips_c1();
        int cyc, last_n, first_last;
        b_out_ready = 1'b0;
        send(1'b1, PC, KC);
        n_tests++; if (b_rnd_key_o !== RK1C) begin n_fail++; $display("FAIL c1_rk1: got %h expected %h", b_rnd_key_o, RK1C); end
        cyc = 1; last_n = 0; first_last = 0;
        while (b_out_valid !== 1'b1 && cyc < 60) begin
            if (b_rnd_last_o === 1'b1) begin
                if (last_n == 0) first_last = cyc;
                last_n++;
            end
            @(posedge clk); #1; cyc++;
            if (cyc == 2) begin
                n_tests++; if (b_rnd_key_o !== RK1C) begin n_fail++; $display("FAIL c1_rk1_hold: got %h expected %h", b_rnd_key_o, RK1C); end
            end
        end
        n_tests++; if (cyc != 21) begin n_fail++; $display("FAIL c1_latency: got T+%0d expected T+21", cyc); end
        n_tests++; if (last_n != 2 || first_last != 19) begin n_fail++; $display("FAIL c1_last: got %0d cycles from T+%0d expected 2 from T+19", last_n, first_last); end
        n_tests++; if (b_out_cipher !== CC) begin n_fail++; $display("FAIL c1_cipher: got %h expected %h", b_out_cipher, CC); end
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        n_tests++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL c1_release: got busy=%b expected 0", b_busy); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        a_out_ready = 1'b1;
        send(1'b0, PB, KB);
        a_in_plain = PC; a_in_key = KC; a_in_valid = 1'b1;
        cyc = 1;
        while (a_out_valid !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        n_tests++; if (cyc != 11 || a_out_cipher !== CB) begin n_fail++; $display("FAIL b2b_first: got T+%0d %h expected T+11 %h", cyc, a_out_cipher, CB); end
        n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_done: got %b expected 1", a_in_ready); end
        @(posedge clk); #1;
        n_tests++; if (a_out_valid !== 1'b0 || a_busy !== 1'b1 || a_rnd_key_o !== RK1C) begin
            n_fail++; $display("FAIL b2b_reload: got valid=%b busy=%b rk=%h expected 0 1 %h", a_out_valid, a_busy, a_rnd_key_o, RK1C); end
        cyc = 1;
        while (a_out_valid !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        n_tests++; if (cyc != 11 || a_out_cipher !== CC) begin n_fail++; $display("FAIL b2b_second: got +%0d %h expected +11 %h", cyc, a_out_cipher, CC); end
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy=%b expected 0", a_busy); end
    endtask

    task automatic test_backpressure();
        int cyc;
        a_out_ready = 1'b0;
        send(1'b0, PC, KC);
        cyc = 1;
        while (a_out_valid !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        n_tests++; if (cyc != 11) begin n_fail++; $display("FAIL bp_latency: got T+%0d expected T+11", cyc); end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (a_out_valid !== 1'b1 || a_out_cipher !== CC || a_in_ready !== 1'b0 || a_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got valid=%b ct=%h ready=%b busy=%b expected 1 %h 0 1",
                         i, a_out_valid, a_out_cipher, a_in_ready, a_busy, CC);
            end
            @(posedge clk); #1;
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        n_tests++; if (a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got busy=%b valid=%b ready=%b expected 0 0 1", a_busy, a_out_valid, a_in_ready); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit seen;
        a_out_ready = 1'b0;
        send(1'b0, PB, KB);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_rnd_last_o !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_flags: got valid=%b busy=%b last=%b expected 0 0 0", a_out_valid, a_busy, a_rnd_last_o); end
        n_tests++; if (a_rnd_state_o !== '0 || a_rnd_key_o !== '0) begin
            n_fail++; $display("FAIL rstmid_rnd: got st=%h key=%h expected 0 0", a_rnd_state_o, a_rnd_key_o); end
        seen = 1'b0;
        repeat (12) begin
            if (a_out_valid === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_tests++; if (seen) begin n_fail++; $display("FAIL rstmid_no_output: got out_valid=1 expected no output"); end
        send(1'b0, PB, KB);
        cyc = 1;
        while (a_out_valid !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        n_tests++; if (cyc != 11 || a_out_cipher !== CB) begin n_fail++; $display("FAIL rstmid_redo: got T+%0d %h expected T+11 %h", cyc, a_out_cipher, CB); end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
    endtask

    task automatic test_input_change();
        int cyc;
        b_out_ready = 1'b0;
        send(1'b1, PC, KC);
        cyc = 1;
        while (b_out_valid !== 1'b1 && cyc < 60) begin
            b_in_plain = {$urandom, $urandom, $urandom, $urandom};
            b_in_key   = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1; cyc++;
        end
        n_tests++; if (cyc != 21 || b_out_cipher !== CC) begin n_fail++; $display("FAIL inchg_cipher: got T+%0d %h expected T+21 %h", cyc, b_out_cipher, CC); end
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_plain = '0; a_in_key = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_plain = '0; b_in_key = '0; b_out_ready = 1'b0;
        test_reset();
        test_fips_b();
        test_fips_c1();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_input_change();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
